// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter and its in-order ID FIFO.
package ram_port_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [0:0] {
        REQ_LOADER = 1'b0,
        REQ_CORE   = 1'b1
    } req_id_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_bundle_t;

    // A depth-1 FIFO still needs a one-bit pointer to stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs; zero-latency head, pointers wrap modulo DEPTH.
// Backpressure: a push is taken when not full, or when full and a pop lands in the same cycle.
module arb_id_fifo
    import ram_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & ((int'(count_q) < DEPTH) | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter of SPI loader and core onto one RAM port; grant and response are same-cycle.
// Backpressure: selection locks while the memory withholds mem_gnt_i; issue stalls at MAX_OUTST outstanding.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic        load_mode_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        proto_err_o
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    req_bundle_t        bundle [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    req_id_e            sel;
    req_id_e            last_q;
    req_id_e            lock_sel_q;
    logic               locked_q;
    logic               proto_err_q;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [0:0]         head_dat;
    logic               pop;
    logic               space;
    logic               req_int;
    logic               hs;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bundle[i].we    = we_i[i];
            bundle[i].be    = be_i[i*4 +: 4];
            bundle[i].addr  = addr_i[i*32 +: 32];
            bundle[i].wdata = wdata_i[i*32 +: 32];
        end
    end

    assign elig = req_i & {~load_mode_i, 1'b1};

    always_comb begin
        sel = REQ_LOADER;
        if (locked_q) begin
            sel = lock_sel_q;
        end else if (&elig) begin
            sel = (last_q == REQ_LOADER) ? REQ_CORE : REQ_LOADER;
        end else if (elig[1]) begin
            sel = REQ_CORE;
        end
    end

    // A response retiring this cycle frees its slot for a same-cycle issue.
    assign pop     = mem_rvalid_i & ~fifo_empty & ~rst_sys_i;
    assign space   = (int'(fifo_count) < MAX_OUTST) | pop;
    assign req_int = (locked_q ? req_i[lock_sel_q] : |elig) & space & ~rst_sys_i;
    assign hs      = req_int & mem_gnt_i;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            locked_q    <= 1'b0;
            lock_sel_q  <= REQ_LOADER;
            last_q      <= REQ_CORE;
            proto_err_q <= 1'b0;
        end else begin
            locked_q <= req_int & ~mem_gnt_i;
            if (req_int && !mem_gnt_i) begin
                lock_sel_q <= sel;
            end
            if (hs) begin
                last_q <= sel;
            end
            if (mem_rvalid_i && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (1)
    ) u_id_fifo (
        .clk      (clk_sys_i),
        .rst      (rst_sys_i),
        .push     (hs),
        .push_dat (sel),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign mem_req_o   = req_int;
    assign mem_we_o    = bundle[sel].we & ~rst_sys_i;
    assign mem_be_o    = rst_sys_i ? '0 : bundle[sel].be;
    assign mem_addr_o  = rst_sys_i ? '0 : bundle[sel].addr;
    assign mem_wdata_o = rst_sys_i ? '0 : bundle[sel].wdata;

    assign gnt_o[0]    = hs & (sel == REQ_LOADER);
    assign gnt_o[1]    = hs & (sel == REQ_CORE);
    assign rvalid_o[0] = pop & (head_dat == 1'b0);
    assign rvalid_o[1] = pop & (head_dat == 1'b1);
    assign rdata_o     = (mem_rvalid_i && !rst_sys_i) ? mem_rdata_i : '0;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: grants and responses are checked by a scoreboard monitor.
module tb_ram_port_arbiter;

    logic        clk_sys_i = 1'b0;
    logic        rst_sys_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        load_mode_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  gnt_q [$];
    logic [33:0] rsp_q [$];

    ram_port_arbiter #(.MAX_OUTST(2)) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_sys_i    (rst_sys_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .load_mode_i  (load_mode_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic exp_rsp(input logic [1:0] rv, input logic [31:0] data);
        rsp_q.push_back({rv, data});
    endtask

    // Monitor: every observed grant or response must match the next expected entry.
    always @(negedge clk_sys_i) begin
        logic [1:0]  g;
        logic [33:0] r;
        if (gnt_o != 2'b00) begin
            if (gnt_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL gnt_unexpected actual=%b required=none", gnt_o);
            end else begin
                g = gnt_q.pop_front();
                chk("gnt_o", {30'd0, gnt_o}, {30'd0, g});
            end
        end
        if (rvalid_o != 2'b00) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_unexpected actual=%b required=none", rvalid_o);
            end else begin
                r = rsp_q.pop_front();
                chk("rvalid_o", {30'd0, rvalid_o}, {30'd0, r[33:32]});
                chk("rdata_o", rdata_o, r[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with busy inputs: every output must still read zero.
        rst_sys_i    = 1'b1;
        req_i        = 2'b11;
        we_i         = 2'b11;
        be_i         = 8'hFF;
        addr_i       = {32'h200, 32'h100};
        wdata_i      = {32'hC0C0, 32'hA0A0};
        load_mode_i  = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234;
        @(negedge clk_sys_i);
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err_o}, 32'd0);
        tick();
        we_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; req_i = 2'b00;
        rst_sys_i = 1'b0;
        tick();

        // Round robin with both requesting; loader wins the first tie.
        req_i = 2'b11; mem_gnt_i = 1'b1;
        gnt_q.push_back(2'b01);
        @(negedge clk_sys_i);
        chk("rr_addr_first", mem_addr_o, 32'h100);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA1;
        gnt_q.push_back(2'b10); exp_rsp(2'b01, 32'hA1);
        @(negedge clk_sys_i);
        chk("rr_addr_second", mem_addr_o, 32'h200);
        tick();
        mem_rdata_i = 32'hA2;
        gnt_q.push_back(2'b01); exp_rsp(2'b10, 32'hA2);
        tick();
        mem_rdata_i = 32'hA3;
        gnt_q.push_back(2'b10); exp_rsp(2'b01, 32'hA3);
        tick();
        req_i = 2'b00; mem_rdata_i = 32'hA4;
        exp_rsp(2'b10, 32'hA4);
        tick();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;

        // Load mode masks the core.
        load_mode_i = 1'b1; req_i = 2'b11; mem_gnt_i = 1'b1;
        gnt_q.push_back(2'b01);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hB1;
        gnt_q.push_back(2'b01); exp_rsp(2'b01, 32'hB1);
        tick();
        req_i = 2'b10; mem_rdata_i = 32'hB2;
        exp_rsp(2'b01, 32'hB2);
        @(negedge clk_sys_i);
        chk("load_core_masked", {31'd0, mem_req_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0; req_i = 2'b00; load_mode_i = 1'b0;

        // Outstanding limit, then issue in the same cycle as a retire.
        req_i = 2'b01;
        gnt_q.push_back(2'b01);
        tick();
        gnt_q.push_back(2'b01);
        tick();
        @(negedge clk_sys_i);
        chk("outst_full_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC1;
        gnt_q.push_back(2'b01); exp_rsp(2'b01, 32'hC1);
        @(negedge clk_sys_i);
        chk("outst_retire_gnt", {30'd0, gnt_o}, 32'd1);
        tick();
        req_i = 2'b00; mem_rdata_i = 32'hC2;
        exp_rsp(2'b01, 32'hC2);
        tick();
        mem_rdata_i = 32'hC3;
        exp_rsp(2'b01, 32'hC3);
        tick();
        mem_rvalid_i = 1'b0;

        // Core read then loader write; responses return in issue order.
        req_i = 2'b10; we_i = 2'b00; addr_i = {32'h10, 32'h20};
        be_i = 8'h0F; wdata_i = {32'h0, 32'h55};
        gnt_q.push_back(2'b10);
        @(negedge clk_sys_i);
        chk("rd_addr", mem_addr_o, 32'h10);
        chk("rd_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        req_i = 2'b01; we_i = 2'b01;
        gnt_q.push_back(2'b01);
        @(negedge clk_sys_i);
        chk("wr_we", {31'd0, mem_we_o}, 32'd1);
        chk("wr_wdata", mem_wdata_o, 32'h55);
        chk("wr_be", {28'd0, mem_be_o}, 32'hF);
        tick();
        req_i = 2'b00; we_i = 2'b00; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        exp_rsp(2'b10, 32'hDEADBEEF);
        tick();
        mem_rdata_i = 32'h0;
        exp_rsp(2'b01, 32'h0);
        tick();
        mem_rvalid_i = 1'b0;

        // Core stalled by memory; loader arrival and load mode must not steal it.
        addr_i = {32'h300, 32'h400}; req_i = 2'b10;
        @(negedge clk_sys_i);
        chk("lock_req", {31'd0, mem_req_o}, 32'd1);
        chk("lock_addr_c0", mem_addr_o, 32'h300);
        tick();
        req_i = 2'b11; load_mode_i = 1'b1;
        @(negedge clk_sys_i);
        chk("lock_addr_c1", mem_addr_o, 32'h300);
        tick();
        @(negedge clk_sys_i);
        chk("lock_addr_c2", mem_addr_o, 32'h300);
        tick();
        mem_gnt_i = 1'b1;
        gnt_q.push_back(2'b10);
        @(negedge clk_sys_i);
        chk("lock_addr_gnt", mem_addr_o, 32'h300);
        tick();
        gnt_q.push_back(2'b01);
        @(negedge clk_sys_i);
        chk("unlock_addr", mem_addr_o, 32'h400);
        tick();
        req_i = 2'b00; mem_gnt_i = 1'b0; load_mode_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD1;
        exp_rsp(2'b10, 32'hD1);
        tick();
        mem_rdata_i = 32'hD2;
        exp_rsp(2'b01, 32'hD2);
        tick();

        // Response with nothing outstanding is a protocol error.
        mem_rdata_i = 32'h77;
        @(negedge clk_sys_i);
        chk("perr_rvalid", {30'd0, rvalid_o}, 32'd0);
        chk("perr_before", {31'd0, proto_err_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_sys_i);
        chk("perr_sticky", {31'd0, proto_err_o}, 32'd1);
        tick();

        // Reset in the middle of traffic discards the outstanding ID.
        req_i = 2'b01; mem_gnt_i = 1'b1; we_i = 2'b01;
        gnt_q.push_back(2'b01);
        tick();
        req_i = 2'b11;
        #1 rst_sys_i = 1'b1;
        #1;
        chk("arst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("arst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("arst_proto_err", {31'd0, proto_err_o}, 32'd0);
        tick();
        req_i = 2'b00; mem_gnt_i = 1'b0; we_i = 2'b00;
        rst_sys_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
        @(negedge clk_sys_i);
        chk("post_rst_rvalid", {30'd0, rvalid_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_sys_i);
        chk("post_rst_perr", {31'd0, proto_err_o}, 32'd1);
        tick();

        chk("sb_gnt_drain", gnt_q.size(), 32'd0);
        chk("sb_rsp_drain", rsp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
